text_console_writer: RTL and testbench

Avalon-MM master that turns a byte stream of characters into writes to the 80x30 text VRAM of the VGA text display, which sits directly downstream on the same Avalon fabric. It tracks a hardware cursor, packs each glyph and its colour-attribute byte into the correct half of a VRAM word, and interprets a small set of control codes. It also performs hardware scrolling (row copy via read/write) and full-screen clear, so software only has to push bytes.

---
 rtl/text_console_writer.sv | 249 ++++++++++++++++++++++++
 tb/tb_text_console_writer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Avalon-MM master that turns a character byte stream into writes to the text VRAM.
// It tracks a cursor and handles control codes, hardware scroll and full-screen clear.
module text_console_writer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int RD_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CH_VALID,
    output logic        CH_READY,
    input  logic [7:0]  CH_DATA,
    input  logic [7:0]  ATTR,
    output logic [11:0] M_ADDR,
    output logic        M_READ,
    output logic        M_WRITE,
    output logic [3:0]  M_BYTE_EN,
    output logic [31:0] M_WRITEDATA,
    input  logic [31:0] M_READDATA,
    input  logic        M_WAITREQUEST,
    output logic [6:0]  CUR_COL,
    output logic [4:0]  CUR_ROW,
    output logic        BUSY
);

    localparam logic [11:0] COLS_W      = 12'(COLS);
    localparam logic [11:0] HALF_ROW    = 12'(COLS / 2);
    localparam logic [11:0] LAST_SCROLL = 12'((ROWS - 1) * COLS / 2 - 1);
    localparam logic [11:0] LAST_WORD   = 12'(ROWS * COLS / 2 - 1);
    localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);
    localparam logic [7:0]  LAT_LAST    = 8'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHAR_WR,
        SCR_RD,
        SCR_WAIT,
        SCR_WR,
        FILL
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic [7:0]  ch_q;
    logic [7:0]  attr_q;
    logic [11:0] char_addr;
    logic        odd_q;
    logic        need_scroll;
    logic [11:0] work_addr;
    logic [7:0]  lat_cnt;
    logic [31:0] rd_data;

    logic        accept;
    logic        cmd_ok;
    logic        is_ctrl;
    logic        is_lf;
    logic        is_cr;
    logic        is_bs;
    logic        is_ff;
    logic        wrap;
    logic        at_bottom;
    logic [11:0] char_index;
    logic [31:0] blank_word;

    assign accept     = CH_VALID && (state == IDLE);
    assign cmd_ok     = !M_WAITREQUEST;
    assign is_ctrl    = !CH_DATA[7];
    assign is_lf      = is_ctrl && (CH_DATA[6:0] == 7'h0A);
    assign is_cr      = is_ctrl && (CH_DATA[6:0] == 7'h0D);
    assign is_bs      = is_ctrl && (CH_DATA[6:0] == 7'h08);
    assign is_ff      = is_ctrl && (CH_DATA[6:0] == 7'h0C);
    assign wrap       = (cur_col == LAST_COL);
    assign at_bottom  = (cur_row == LAST_ROW);
    // COLS is even, so the half-word parity of the cell equals the column parity.
    assign char_index = 12'(cur_row) * COLS_W + 12'(cur_col);
    assign blank_word = {8'h20, attr_q, 8'h20, attr_q};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_ff) begin
                        next_state = FILL;
                    end else if (is_lf) begin
                        next_state = at_bottom ? SCR_RD : IDLE;
                    end else if (is_cr || is_bs) begin
                        next_state = IDLE;
                    end else begin
                        next_state = CHAR_WR;
                    end
                end
            end
            CHAR_WR: begin
                if (cmd_ok) begin
                    next_state = need_scroll ? SCR_RD : IDLE;
                end
            end
            SCR_RD: begin
                if (cmd_ok) begin
                    next_state = SCR_WAIT;
                end
            end
            SCR_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    next_state = SCR_WR;
                end
            end
            SCR_WR: begin
                if (cmd_ok) begin
                    next_state = (work_addr == LAST_SCROLL) ? FILL : SCR_RD;
                end
            end
            FILL: begin
                if (cmd_ok && (work_addr == LAST_WORD)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The cursor moves on accept, so the write target is frozen from the pre-command position.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cur_col     <= '0;
            cur_row     <= '0;
            ch_q        <= '0;
            attr_q      <= '0;
            char_addr   <= '0;
            odd_q       <= 1'b0;
            need_scroll <= 1'b0;
            work_addr   <= '0;
            lat_cnt     <= '0;
            rd_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ch_q        <= CH_DATA;
                        attr_q      <= ATTR;
                        char_addr   <= {1'b0, char_index[11:1]};
                        odd_q       <= cur_col[0];
                        need_scroll <= 1'b0;
                        work_addr   <= '0;
                        if (is_ff) begin
                            cur_col <= '0;
                            cur_row <= '0;
                        end else if (is_lf) begin
                            cur_col <= '0;
                            if (!at_bottom) begin
                                cur_row <= cur_row + 5'd1;
                            end
                        end else if (is_cr) begin
                            cur_col <= '0;
                        end else if (is_bs) begin
                            if (cur_col != '0) begin
                                cur_col <= cur_col - 7'd1;
                            end
                        end else if (wrap) begin
                            cur_col <= '0;
                            if (at_bottom) begin
                                need_scroll <= 1'b1;
                            end else begin
                                cur_row <= cur_row + 5'd1;
                            end
                        end else begin
                            cur_col <= cur_col + 7'd1;
                        end
                    end
                end
                SCR_RD: begin
                    if (cmd_ok) begin
                        lat_cnt <= '0;
                    end
                end
                SCR_WAIT: begin
                    lat_cnt <= lat_cnt + 8'd1;
                    if (lat_cnt == LAT_LAST) begin
                        rd_data <= M_READDATA;
                    end
                end
                // Copy index runs straight from the last copied word into the blank-row fill.
                SCR_WR, FILL: begin
                    if (cmd_ok) begin
                        work_addr <= work_addr + 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        M_READ      = 1'b0;
        M_WRITE     = 1'b0;
        M_ADDR      = '0;
        M_BYTE_EN   = '0;
        M_WRITEDATA = '0;
        case (state)
            CHAR_WR: begin
                M_WRITE = 1'b1;
                M_ADDR  = char_addr;
                if (odd_q) begin
                    M_BYTE_EN   = 4'b1100;
                    M_WRITEDATA = {ch_q, attr_q, 16'h0000};
                end else begin
                    M_BYTE_EN   = 4'b0011;
                    M_WRITEDATA = {16'h0000, ch_q, attr_q};
                end
            end
            SCR_RD: begin
                M_READ = 1'b1;
                M_ADDR = work_addr + HALF_ROW;
            end
            SCR_WR: begin
                M_WRITE     = 1'b1;
                M_ADDR      = work_addr;
                M_BYTE_EN   = 4'b1111;
                M_WRITEDATA = rd_data;
            end
            FILL: begin
                M_WRITE     = 1'b1;
                M_ADDR      = work_addr;
                M_BYTE_EN   = 4'b1111;
                M_WRITEDATA = blank_word;
            end
            default: ;
        endcase
    end

    assign CH_READY = (state == IDLE) && !RESET;
    assign BUSY     = (state != IDLE);
    assign CUR_COL  = cur_col;
    assign CUR_ROW  = cur_row;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a VRAM slave model and an expected-transaction queue.
module tb_text_console_writer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CH_VALID;
    logic        CH_READY;
    logic [7:0]  CH_DATA;
    logic [7:0]  ATTR;
    logic [11:0] M_ADDR;
    logic        M_READ;
    logic        M_WRITE;
    logic [3:0]  M_BYTE_EN;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_WAITREQUEST;
    logic [6:0]  CUR_COL;
    logic [4:0]  CUR_ROW;
    logic        BUSY;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } bus_op_t;

    bus_op_t     exp_q[$];
    logic [31:0] model_mem [0:1199];
    logic [31:0] vram [0:1199];
    logic [31:0] rdata;
    int          tests = 0;
    int          fails = 0;
    int          mc = 0;
    int          mr = 0;

    text_console_writer dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CH_VALID     (CH_VALID),
        .CH_READY     (CH_READY),
        .CH_DATA      (CH_DATA),
        .ATTR         (ATTR),
        .M_ADDR       (M_ADDR),
        .M_READ       (M_READ),
        .M_WRITE      (M_WRITE),
        .M_BYTE_EN    (M_BYTE_EN),
        .M_WRITEDATA  (M_WRITEDATA),
        .M_READDATA   (M_READDATA),
        .M_WAITREQUEST(M_WAITREQUEST),
        .CUR_COL      (CUR_COL),
        .CUR_ROW      (CUR_ROW),
        .BUSY         (BUSY)
    );

    always #10 CLK = ~CLK;

    // VRAM slave with one cycle of read latency; reset loads a recognisable pattern.
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 1200; i++) vram[i] <= 32'hA5A50000 | 32'(i);
            rdata <= '0;
        end else begin
            if (M_WRITE && !M_WAITREQUEST) begin
                for (int b = 0; b < 4; b++) begin
                    if (M_BYTE_EN[b]) vram[M_ADDR][8*b +: 8] <= M_WRITEDATA[8*b +: 8];
                end
            end
            if (M_READ && !M_WAITREQUEST) rdata <= vram[M_ADDR];
        end
    end
    assign M_READDATA = rdata;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_write(input logic [11:0] addr, input logic [3:0] be, input logic [31:0] data);
        exp_q.push_back('{1'b1, addr, be, data});
        for (int b = 0; b < 4; b++) begin
            if (be[b]) model_mem[addr][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic push_read(input logic [11:0] addr);
        exp_q.push_back('{1'b0, addr, 4'h0, 32'h0});
    endtask

    task automatic model_scroll(input logic [7:0] attr);
        for (int w = 0; w < 1160; w++) begin
            push_read(12'(w + 40));
            push_write(12'(w), 4'hF, model_mem[w + 40]);
        end
        for (int w = 1160; w < 1200; w++) push_write(12'(w), 4'hF, {8'h20, attr, 8'h20, attr});
    endtask

    task automatic model_advance_row(input logic [7:0] attr);
        if (mr == 29) model_scroll(attr);
        else mr++;
    endtask

    task automatic model_byte(input logic [7:0] ch, input logic [7:0] attr);
        int idx;
        if (!ch[7] && ch[6:0] == 7'h0A) begin
            mc = 0;
            model_advance_row(attr);
        end else if (!ch[7] && ch[6:0] == 7'h0D) begin
            mc = 0;
        end else if (!ch[7] && ch[6:0] == 7'h08) begin
            if (mc > 0) mc--;
        end else if (!ch[7] && ch[6:0] == 7'h0C) begin
            for (int w = 0; w < 1200; w++) push_write(12'(w), 4'hF, {8'h20, attr, 8'h20, attr});
            mc = 0;
            mr = 0;
        end else begin
            idx = mr * 80 + mc;
            if (idx % 2 == 1) push_write(12'(idx / 2), 4'b1100, {ch, attr, 16'h0000});
            else push_write(12'(idx / 2), 4'b0011, {16'h0000, ch, attr});
            mc++;
            if (mc == 80) begin
                mc = 0;
                model_advance_row(attr);
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the cycle after acceptance.
    task automatic apply_stimulus(input logic [7:0] ch, input logic [7:0] attr);
        int guard = 0;
        model_byte(ch, attr);
        CH_DATA  = ch;
        ATTR     = attr;
        CH_VALID = 1'b1;
        #1;
        while (!CH_READY && guard < 10000) begin
            @(negedge CLK);
            #1;
            guard++;
        end
        if (!CH_READY) check_output("accept_timeout", 64'(CH_READY), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        CH_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int cycles, output logic rdy_seen);
        cycles   = 0;
        rdy_seen = 1'b0;
        while (BUSY && cycles < budget) begin
            if (CH_READY) rdy_seen = 1'b1;
            cycles++;
            @(negedge CLK);
        end
    endtask

    task automatic check_cursor(input string tag);
        check_output(tag, {52'h0, CUR_ROW, CUR_COL}, {52'h0, 5'(mr), 7'(mc)});
    endtask

    initial begin
        int          cyc;
        int          guard;
        logic        rdy;
        logic        hit;
        bus_op_t     e;
        logic [63:0] obs;
        logic [63:0] expv;

        RESET         = 1'b1;
        CH_VALID      = 1'b0;
        CH_DATA       = 8'h00;
        ATTR          = 8'h00;
        M_WAITREQUEST = 1'b0;
        for (int i = 0; i < 1200; i++) model_mem[i] = 32'hA5A50000 | 32'(i);

        fork
            forever begin
                @(negedge CLK);
                #1;
                if (!RESET && (M_READ || M_WRITE) && !M_WAITREQUEST) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $error("[TB] FAIL unexpected_cmd: observed addr %0h expected no command", M_ADDR);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("rw_exclusive", {63'h0, M_READ & M_WRITE}, 64'h0);
                        obs  = M_WRITE ? {15'h0, 1'b1, M_ADDR, M_BYTE_EN, M_WRITEDATA}
                                       : {15'h0, 1'b0, M_ADDR, 36'h0};
                        expv = e.wr ? {15'h0, 1'b1, e.addr, e.be, e.data}
                                    : {15'h0, 1'b0, e.addr, 36'h0};
                        check_output("bus_op", obs, expv);
                    end
                end
            end
        join_none

        repeat (3) @(negedge CLK);
        check_output("reset_outputs", {CH_READY, M_READ, M_WRITE, M_ADDR, M_BYTE_EN, M_WRITEDATA,
                                        CUR_COL, CUR_ROW, BUSY}, 64'h0);
        RESET = 1'b0;
        @(negedge CLK);
        check_output("ready_after_reset", 64'(CH_READY), 64'd1);

        apply_stimulus(8'h41, 8'h1F);
        check_output("wr_latency", {62'h0, M_WRITE, BUSY}, 64'h3);
        check_cursor("cursor_after_A");
        @(negedge CLK);
        check_output("char_rate", 64'(CH_READY), 64'd1);

        apply_stimulus(8'hC2, 8'h20);
        check_cursor("cursor_after_B");
        for (int i = 0; i < 77; i++) apply_stimulus(8'h61 + 8'(i % 26), 8'h07);
        apply_stimulus(8'hC2, 8'h20);
        check_cursor("cursor_wrap");

        apply_stimulus(8'h0A, 8'h07);
        check_output("lf_no_stall", {62'h0, CH_READY, BUSY}, 64'h2);
        check_cursor("cursor_lf");
        for (int i = 0; i < 27; i++) apply_stimulus(8'h0A, 8'h07);
        for (int i = 0; i < 5; i++) apply_stimulus(8'h30 + 8'(i), 8'h1E);
        check_cursor("cursor_29_5");

        apply_stimulus(8'h0A, 8'h07);
        check_cursor("cursor_scroll");
        wait_idle(5000, cyc, rdy);
        check_output("scroll_cycles", 64'(cyc), 64'd3520);
        check_output("scroll_queue_empty", 64'(exp_q.size()), 64'd0);
        check_output("scroll_last_row", {32'h0, vram[1199]}, {32'h0, 32'h20072007});

        apply_stimulus(8'h0C, 8'h34);
        check_cursor("cursor_clear");
        wait_idle(3000, cyc, rdy);
        check_output("clear_cycles", 64'(cyc), 64'd1200);
        check_output("clear_ready_low", 64'(rdy), 64'd0);
        check_output("clear_queue_empty", 64'(exp_q.size()), 64'd0);

        M_WAITREQUEST = 1'b1;
        apply_stimulus(8'h5A, 8'h4E);
        for (int i = 0; i < 5; i++) begin
            check_output("stall_hold", {15'h0, M_WRITE, M_ADDR, M_BYTE_EN, M_WRITEDATA},
                         {15'h0, 1'b1, 12'h000, 4'b0011, 32'h00005A4E});
            @(negedge CLK);
        end
        M_WAITREQUEST = 1'b0;
        @(negedge CLK);
        check_output("stall_done", {62'h0, BUSY, CH_READY}, 64'h1);
        check_output("stall_queue_empty", 64'(exp_q.size()), 64'd0);
        check_cursor("cursor_after_stall");

        apply_stimulus(8'h08, 8'h00);
        check_cursor("bs_from_col1");
        apply_stimulus(8'h08, 8'h00);
        check_cursor("bs_at_col0");
        check_output("bs_no_bus", {61'h0, BUSY, M_WRITE, M_READ}, 64'h0);

        for (int i = 0; i < 29; i++) apply_stimulus(8'h0A, 8'h07);
        check_cursor("cursor_row29");
        apply_stimulus(8'h0A, 8'h07);
        guard = 0;
        hit   = 1'b0;
        while (!hit && guard < 5000) begin
            @(negedge CLK);
            #2;
            hit = M_WRITE && (M_ADDR == 12'd600);
            guard++;
        end
        check_output("reach_w600", 64'(hit), 64'd1);
        #1 RESET = 1'b1;
        #1;
        check_output("reset_async", {CH_READY, M_READ, M_WRITE, M_ADDR, M_BYTE_EN, M_WRITEDATA,
                                      CUR_COL, CUR_ROW, BUSY}, 64'h0);
        exp_q.delete();
        mc = 0;
        mr = 0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check_output("ready_after_reset2", 64'(CH_READY), 64'd1);

        apply_stimulus(8'h51, 8'h5A);
        wait_idle(100, cyc, rdy);
        @(negedge CLK);
        check_cursor("cursor_after_reset_char");
        check_output("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
